alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter_if.sv | 48 ++++
 rtl/alu_share_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the shared bitwise unit.
// The arbiter takes the slave side; requesters and the unit together form the master side.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             a_valid;
  logic             a_ready;
  logic [1:0]       a_op;
  logic [WIDTH-1:0] a_first;
  logic [WIDTH-1:0] a_second;
  logic             a_resp_valid;
  logic             a_resp_ready;

  logic             b_valid;
  logic             b_ready;
  logic [1:0]       b_op;
  logic [WIDTH-1:0] b_first;
  logic [WIDTH-1:0] b_second;
  logic             b_resp_valid;
  logic             b_resp_ready;

  logic [1:0]       unit_op;
  logic [WIDTH-1:0] unit_first;
  logic [WIDTH-1:0] unit_second;
  logic [WIDTH-1:0] unit_result;

  logic [WIDTH-1:0] resp_data;
  logic             grant_id;
  logic             busy;

  modport slave (
    input  a_valid, a_op, a_first, a_second, a_resp_ready,
    input  b_valid, b_op, b_first, b_second, b_resp_ready,
    input  unit_result,
    output a_ready, a_resp_valid, b_ready, b_resp_valid,
    output unit_op, unit_first, unit_second,
    output resp_data, grant_id, busy
  );

  modport master (
    output a_valid, a_op, a_first, a_second, a_resp_ready,
    output b_valid, b_op, b_first, b_second, b_resp_ready,
    output unit_result,
    input  a_ready, a_resp_valid, b_ready, b_resp_valid,
    input  unit_op, unit_first, unit_second,
    input  resp_data, grant_id, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter for one shared XOR/AND/OR/NOR unit: IDLE -> EXEC -> RESP.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise A has fixed priority.
module alu_share_arbiter #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  alu_share_arbiter_if.slave bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] first_q, first_d;
  logic [WIDTH-1:0] second_q, second_d;
  logic [WIDTH-1:0] resp_q, resp_d;
  logic             grant_q, grant_d;
  logic             win_b;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  // On a tie the requester that was not served last wins.
  assign win_b = bus.b_valid & (~bus.a_valid | ~last_q);
`else
  assign win_b = bus.b_valid & ~bus.a_valid;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      first_q  <= '0;
      second_q <= '0;
      resp_q   <= '0;
      grant_q  <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      first_q  <= first_d;
      second_q <= second_d;
      resp_q   <= resp_d;
      grant_q  <= grant_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    op_d             = op_q;
    first_d          = first_q;
    second_d         = second_q;
    resp_d           = resp_q;
    grant_d          = grant_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    last_d           = last_q;
`endif
    bus.a_ready      = 1'b0;
    bus.b_ready      = 1'b0;
    bus.a_resp_valid = 1'b0;
    bus.b_resp_valid = 1'b0;
    bus.unit_op      = '0;
    bus.unit_first   = '0;
    bus.unit_second  = '0;

    case (state_q)
      S_IDLE: begin
        bus.a_ready = bus.a_valid & ~win_b;
        bus.b_ready = win_b;
        if (bus.a_valid | bus.b_valid) begin
          state_d  = S_EXEC;
          cnt_d    = CNT_LOAD;
          grant_d  = win_b;
          op_d     = win_b ? bus.b_op     : bus.a_op;
          first_d  = win_b ? bus.b_first  : bus.a_first;
          second_d = win_b ? bus.b_second : bus.a_second;
        end
      end
      S_EXEC: begin
        bus.unit_op     = op_q;
        bus.unit_first  = first_q;
        bus.unit_second = second_q;
        if (cnt_q == 4'd0) begin
          resp_d  = bus.unit_result;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        bus.a_resp_valid = ~grant_q;
        bus.b_resp_valid = grant_q;
        // Only the owner's resp_ready can retire the response.
        if (grant_q ? bus.b_resp_ready : bus.a_resp_ready) begin
          state_d = S_IDLE;
`ifdef ALU_ARB_ROUND_ROBIN_EN
          last_d  = grant_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.resp_data = resp_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: models the shared unit, scoreboards every response against its request.
module tb_alu_share_arbiter;
  localparam int W  = 32;
  localparam int EC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  alu_share_arbiter_if #(.WIDTH(W)) bus();

  alu_share_arbiter #(.WIDTH(W), .EXEC_CYCLES(EC)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_ref(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      2'b00:   return x ^ y;
      2'b01:   return x & y;
      2'b10:   return x | y;
      default: return ~(x | y);
    endcase
  endfunction

  assign bus.unit_result = alu_ref(bus.unit_op, bus.unit_first, bus.unit_second);

  logic [W-1:0] exp_q[$];
  logic         own_q[$];
  logic         grant_log[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] mon_e;
  logic         mon_o;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: push on request handshake, pop on response handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.a_valid && bus.a_ready) begin
        exp_q.push_back(alu_ref(bus.a_op, bus.a_first, bus.a_second));
        own_q.push_back(1'b0);
        grant_log.push_back(1'b0);
        check("a_accept_excl", W'(bus.b_ready), 0);
      end
      if (bus.b_valid && bus.b_ready) begin
        exp_q.push_back(alu_ref(bus.b_op, bus.b_first, bus.b_second));
        own_q.push_back(1'b1);
        grant_log.push_back(1'b1);
        check("b_accept_excl", W'(bus.a_ready), 0);
      end
      if ((bus.a_resp_valid && bus.a_resp_ready) || (bus.b_resp_valid && bus.b_resp_ready)) begin
        check("resp_has_request", W'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          mon_o = own_q.pop_front();
          check("resp_data", bus.resp_data, mon_e);
          check("resp_owner", W'(bus.b_resp_valid), W'(mon_o));
          check("resp_other_low", W'(bus.a_resp_valid & bus.b_resp_valid), 0);
          check("resp_grant_id", W'(bus.grant_id), W'(mon_o));
        end
      end
    end
  end

  task automatic send(input logic who, input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    if (!who) begin
      bus.a_valid = 1'b1; bus.a_op = op; bus.a_first = x; bus.a_second = y;
    end else begin
      bus.b_valid = 1'b1; bus.b_op = op; bus.b_first = x; bus.b_second = y;
    end
    @(negedge clk);
    while (!(who ? bus.b_ready : bus.a_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_in_time", W'(n < 50), 1);
    @(posedge clk); #1;
    if (!who) bus.a_valid = 1'b0;
    else      bus.b_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    @(negedge clk);
    while ((bus.busy || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_in_time", W'(n < 100), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int base;
    int n;
    logic ha, hb, seen;

    reset = 1'b1;
    bus.a_valid = 0; bus.a_op = 0; bus.a_first = 0; bus.a_second = 0; bus.a_resp_ready = 0;
    bus.b_valid = 0; bus.b_op = 0; bus.b_first = 0; bus.b_second = 0; bus.b_resp_ready = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_busy", W'(bus.busy), 0);
    check("rst_grant_id", W'(bus.grant_id), 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_unit_first", bus.unit_first, 0);
    check("rst_resp_valid", W'({bus.a_resp_valid, bus.b_resp_valid}), 0);
    check("rst_state", W'(dbg_state), 0);

    // Single XOR from A
    @(posedge clk); #1;
    bus.a_resp_ready = 1'b1;
    bus.b_resp_ready = 1'b1;
    send(1'b0, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F);
    @(negedge clk);
    check("t1_unit_first", bus.unit_first, 32'hFFFF0000);
    check("t1_unit_second", bus.unit_second, 32'h0F0F0F0F);
    check("t1_unit_op", W'(bus.unit_op), 0);
    check("t1_busy", W'(bus.busy), 1);
    lat = 1;
    while (!bus.a_resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("a_latency", W'(lat), W'(EC + 1));
    check("a_resp_data_val", bus.resp_data, 32'hF0F00F0F);
    check("resp_unit_zero", bus.unit_first, 0);
    @(negedge clk);
    check("idle_after_resp", W'(bus.busy), 0);

    // AND from B, latency
    @(posedge clk); #1;
    send(1'b1, 2'b01, 32'h12345678, 32'h0000FFFF);
    @(negedge clk);
    lat = 1;
    while (!bus.b_resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b_latency", W'(lat), W'(EC + 1));
    check("b_resp_data_val", bus.resp_data, 32'h00005678);
    check("b_resp_a_low", W'(bus.a_resp_valid), 0);
    wait_idle();

    // Backpressure on A while B waits
    @(posedge clk); #1;
    bus.a_resp_ready = 1'b0;
    send(1'b0, 2'b10, 32'hA5A50000, 32'h00005A5A);
    n = 0;
    while (!bus.a_resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_resp_seen", W'(bus.a_resp_valid), 1);
    @(posedge clk); #1;
    bus.b_valid = 1'b1; bus.b_op = 2'b11; bus.b_first = 32'h0F0F0000; bus.b_second = 32'h000000F0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_valid", W'(bus.a_resp_valid), 1);
      check("bp_resp_data", bus.resp_data, 32'hA5A55A5A);
      check("bp_b_ready", W'(bus.b_ready), 0);
    end
    @(posedge clk); #1;
    bus.a_resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_b_accept", W'(bus.b_ready), 1);
    @(posedge clk); #1;
    bus.b_valid = 1'b0;
    wait_idle();

    // Contention: both requesters continuously valid
    @(posedge clk); #1;
    base = grant_log.size();
    bus.a_valid = 1'b1; bus.a_op = 2'($urandom_range(0, 3)); bus.a_first = $urandom; bus.a_second = $urandom;
    bus.b_valid = 1'b1; bus.b_op = 2'($urandom_range(0, 3)); bus.b_first = $urandom; bus.b_second = $urandom;
    n = 0;
    while (grant_log.size() < base + 4 && n < 200) begin
      @(negedge clk);
      ha = bus.a_valid & bus.a_ready;
      hb = bus.b_valid & bus.b_ready;
      @(posedge clk); #1;
      if (ha) begin bus.a_op = 2'($urandom_range(0, 3)); bus.a_first = $urandom; bus.a_second = $urandom; end
      if (hb) begin bus.b_op = 2'($urandom_range(0, 3)); bus.b_first = $urandom; bus.b_second = $urandom; end
      n++;
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    check("contention_in_time", W'(n < 200), 1);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      if (grant_log.size() > base + i) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
        check("contention_grant", W'(grant_log[base + i]), W'(i % 2));
`else
        check("contention_grant", W'(grant_log[base + i]), 0);
`endif
      end
    end

    // A completes last, then reset abandons an A NOR mid-EXEC
    @(posedge clk); #1;
    send(1'b0, 2'b01, 32'hFFFFFFFF, 32'h13579BDF);
    wait_idle();
    @(posedge clk); #1;
    send(1'b0, 2'b11, 32'h0000FFFF, 32'h00FF00FF);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    own_q.delete();
    @(negedge clk);
    check("mid_rst_busy", W'(bus.busy), 0);
    check("mid_rst_unit_first", bus.unit_first, 0);
    check("mid_rst_unit_second", bus.unit_second, 0);
    check("mid_rst_unit_op", W'(bus.unit_op), 0);
    check("mid_rst_resp_data", bus.resp_data, 0);
    seen = 1'b0;
    for (int i = 0; i < EC + 3; i++) begin
      @(negedge clk);
      if (bus.a_resp_valid || bus.b_resp_valid) seen = 1'b1;
    end
    check("mid_rst_no_resp", W'(seen), 0);
    @(posedge clk); #1;
    bus.a_valid = 1'b1; bus.a_op = 2'b00; bus.a_first = 32'h00000001; bus.a_second = 32'h00000003;
    bus.b_valid = 1'b1; bus.b_op = 2'b10; bus.b_first = 32'h00000010; bus.b_second = 32'h00000100;
    @(negedge clk);
    check("post_rst_tie_a", W'(bus.a_ready), 1);
    check("post_rst_tie_b", W'(bus.b_ready), 0);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    wait_idle();

    check("sb_empty", W'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
